// File: rtl/dcpl_drain_if.sv
// Handshake bundle between reconfiguration control / region traffic monitors
// and the dcpl_drain controller. One bit per decoupled region on every signal.
interface dcpl_drain_if #(
    parameter int N_DCPL = 4
);
    logic [N_DCPL-1:0] decouple_req;
    logic [N_DCPL-1:0] req_issue;
    logic [N_DCPL-1:0] req_cmpl;
    logic [N_DCPL-1:0] gate;
    logic [N_DCPL-1:0] decouple;
    logic [N_DCPL-1:0] decouple_done;
    logic [N_DCPL-1:0] drain_timeout;

    modport master (
        output decouple_req, req_issue, req_cmpl,
        input  gate, decouple, decouple_done, drain_timeout
    );

    modport slave (
        input  decouple_req, req_issue, req_cmpl,
        output gate, decouple, decouple_done, drain_timeout
    );
endinterface

// File: rtl/dcpl_drain.sv
// Per-region drain-then-decouple controller (ACTIVE/DRAIN/DCPL/RELEASE).
// Optional drain watchdog enabled by defining DCPL_DRAIN_TIMEOUT_EN.
`ifndef N_REGIONS
`define N_REGIONS 4
`endif

module dcpl_drain #(
    parameter int N_DCPL         = `N_REGIONS,
    parameter int CNT_BITS       = 8,
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic          aclk,
    input  logic          aresetn,
    dcpl_drain_if.slave   bus
);
    typedef enum logic [1:0] {
        ST_ACTIVE  = 2'd0,
        ST_DRAIN   = 2'd1,
        ST_DCPL    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    localparam int SETTLE_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int TMR_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // Both counters terminate on (value == N-1), so zero would never terminate.
    if (SETTLE_CYCLES < 1 || TIMEOUT_CYCLES < 1 || TMR_W < 1) begin : g_bad_params
        $error("dcpl_drain: SETTLE_CYCLES and TIMEOUT_CYCLES must be >= 1");
    end

    logic [N_DCPL-1:0] gate_vec;
    logic [N_DCPL-1:0] decouple_vec;
    logic [N_DCPL-1:0] timeout_vec;

    genvar gi;
    generate
        for (gi = 0; gi < N_DCPL; gi++) begin : g_region
            state_t                state_reg, state_next;
            logic [CNT_BITS-1:0]   cnt_reg, cnt_next;
            logic [SETTLE_W-1:0]   settle_reg, settle_next;
            logic                  req, issue, cmpl, cnt_idle;

            assign req   = bus.decouple_req[gi];
            assign issue = bus.req_issue[gi];
            assign cmpl  = bus.req_cmpl[gi];
            // Drained only when nothing is outstanding and nothing is moving this cycle.
            assign cnt_idle = (cnt_reg == '0) && !issue && !cmpl;

`ifdef DCPL_DRAIN_TIMEOUT_EN
            logic [TMR_W-1:0] tmr_reg, tmr_next;
            logic             tmo_reg, tmo_next;
`endif

            always_comb begin
                state_next  = state_reg;
                cnt_next    = cnt_reg;
                settle_next = settle_reg;
`ifdef DCPL_DRAIN_TIMEOUT_EN
                tmr_next    = tmr_reg;
                tmo_next    = tmo_reg;
`endif
                if (issue && !cmpl && cnt_reg != '1)
                    cnt_next = cnt_reg + CNT_BITS'(1);
                else if (cmpl && !issue && cnt_reg != '0)
                    cnt_next = cnt_reg - CNT_BITS'(1);

                case (state_reg)
                    ST_ACTIVE: begin
                        if (req) begin
                            state_next = ST_DRAIN;
`ifdef DCPL_DRAIN_TIMEOUT_EN
                            tmr_next   = '0;
                            tmo_next   = 1'b0;
`endif
                        end
                    end
                    ST_DRAIN: begin
`ifdef DCPL_DRAIN_TIMEOUT_EN
                        tmr_next = tmr_reg + TMR_W'(1);
`endif
                        if (!req)
                            state_next = ST_ACTIVE;
                        else if (cnt_idle)
                            state_next = ST_DCPL;
`ifdef DCPL_DRAIN_TIMEOUT_EN
                        // Watchdog: give up on lost completions and isolate anyway.
                        else if (tmr_reg == TMR_W'(TIMEOUT_CYCLES - 1)) begin
                            state_next = ST_DCPL;
                            cnt_next   = '0;
                            tmo_next   = 1'b1;
                        end
`endif
                    end
                    ST_DCPL: begin
                        if (!req) begin
                            state_next  = ST_RELEASE;
                            settle_next = '0;
                        end
                    end
                    ST_RELEASE: begin
                        if (req) begin
                            state_next = ST_DRAIN;
`ifdef DCPL_DRAIN_TIMEOUT_EN
                            tmr_next   = '0;
                            tmo_next   = 1'b0;
`endif
                        end else if (settle_reg == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                            state_next = ST_ACTIVE;
                        end else begin
                            settle_next = settle_reg + SETTLE_W'(1);
                        end
                    end
                    default: state_next = ST_ACTIVE;
                endcase
            end

            always_ff @(posedge aclk) begin
                if (!aresetn) begin
                    state_reg  <= ST_ACTIVE;
                    cnt_reg    <= '0;
                    settle_reg <= '0;
`ifdef DCPL_DRAIN_TIMEOUT_EN
                    tmr_reg    <= '0;
                    tmo_reg    <= 1'b0;
`endif
                end else begin
                    state_reg  <= state_next;
                    cnt_reg    <= cnt_next;
                    settle_reg <= settle_next;
`ifdef DCPL_DRAIN_TIMEOUT_EN
                    tmr_reg    <= tmr_next;
                    tmo_reg    <= tmo_next;
`endif
                end
            end

            assign gate_vec[gi]     = (state_reg != ST_ACTIVE);
            assign decouple_vec[gi] = (state_reg == ST_DCPL);
`ifdef DCPL_DRAIN_TIMEOUT_EN
            assign timeout_vec[gi]  = tmo_reg;
`else
            assign timeout_vec[gi]  = 1'b0;
`endif
        end
    endgenerate

    assign bus.gate          = gate_vec;
    assign bus.decouple      = decouple_vec;
    assign bus.decouple_done = decouple_vec;
    assign bus.drain_timeout = timeout_vec;
endmodule
